ee201_gcd_dispatcher: RTL and testbench

EE201_GCD_DISPATCHER -- requirements
Module: ee201_gcd_dispatcher

---
 rtl/ee201_gcd_dispatcher.sv | 199 +++++++++++++++++++
 tb/tb_ee201_gcd_dispatcher.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ee201_gcd_dispatcher.sv
// ee201_gcd_dispatcher: queues operand pairs and feeds them to an EE201 GCD core.
// Define ZERO_BYPASS_EN to resolve zero-operand pairs locally, skipping the core.
module ee201_gcd_dispatcher #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       CEN,
  input  logic       In_valid,
  output logic       In_ready,
  input  logic [7:0] In_A,
  input  logic [7:0] In_B,
  output logic [7:0] Ain,
  output logic [7:0] Bin,
  output logic       Start,
  output logic       Ack,
  input  logic       q_Done,
  input  logic [7:0] AB_GCD,
  output logic       Out_valid,
  input  logic       Out_ready,
  output logic [7:0] Out_A,
  output logic [7:0] Out_B,
  output logic [7:0] Out_GCD,
  output logic       Busy,
  output logic [7:0] Job_count
);

  localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    D_IDLE,
    D_START,
    D_WAIT,
    D_ACK
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [15:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   fifo_cnt;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic [7:0]    head_a;
  logic [7:0]    head_b;
  logic          head_zero;
  logic          slot_free;
  logic          load_ops;
  logic          capture_core;
  logic          capture_zero;
  logic          capture;
  logic [7:0]    cap_a;
  logic [7:0]    cap_b;
  logic [7:0]    cap_gcd;

  assign fifo_empty = (fifo_cnt == '0);
  assign In_ready   = (fifo_cnt != FULL_CNT);
  assign push       = In_valid & In_ready & CEN;
  assign {head_a, head_b} = fifo_mem[rd_ptr];

  // Result slot can take a new record if empty or draining this edge.
  assign slot_free = ~Out_valid | Out_ready;

`ifdef ZERO_BYPASS_EN
  assign head_zero = (head_a == 8'd0) | (head_b == 8'd0);
`else
  assign head_zero = 1'b0;
`endif

  assign capture = capture_core | capture_zero;
  assign cap_a   = capture_zero ? head_a : Ain;
  assign cap_b   = capture_zero ? head_b : Bin;

  // A zero operand makes the other operand the GCD; (0,0) yields 0.
  always_comb begin
    cap_gcd = AB_GCD;
    if (capture_zero) begin
      cap_gcd = (head_a == 8'd0) ? head_b : head_a;
    end
  end

  assign Busy = (state != D_IDLE);

  // Storage write; only the pointers and count need reset.
  always_ff @(posedge Clk) begin
    if (Reset_n && push) begin
      fifo_mem[wr_ptr] <= {In_A, In_B};
    end
  end

  // FIFO pointers and occupancy; pop sees the pre-edge count.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else if (CEN) begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Dispatcher state register.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state <= D_IDLE;
    end else if (CEN) begin
      state <= state_nxt;
    end
  end

  // Next state, pop/capture strobes and Moore handshake outputs.
  always_comb begin
    state_nxt    = state;
    pop          = 1'b0;
    load_ops     = 1'b0;
    capture_core = 1'b0;
    capture_zero = 1'b0;
    Start        = 1'b0;
    Ack          = 1'b0;
    unique case (state)
      D_IDLE: begin
        if (!fifo_empty) begin
          if (head_zero) begin
            if (slot_free) begin
              pop          = 1'b1;
              capture_zero = 1'b1;
            end
          end else begin
            pop       = 1'b1;
            load_ops  = 1'b1;
            state_nxt = D_START;
          end
        end
      end
      D_START: begin
        Start     = 1'b1;
        state_nxt = D_WAIT;
      end
      D_WAIT: begin
        if (q_Done && slot_free) begin
          capture_core = 1'b1;
          state_nxt    = D_ACK;
        end
      end
      D_ACK: begin
        Ack       = 1'b1;
        state_nxt = D_IDLE;
      end
      default: state_nxt = D_IDLE;
    endcase
  end

  // Operands to the core, held from D_START until D_ACK is left.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      Ain <= '0;
      Bin <= '0;
    end else if (CEN && load_ops) begin
      Ain <= head_a;
      Bin <= head_b;
    end
  end

  // Result record, valid flag and job counter.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      Out_valid <= 1'b0;
      Out_A     <= '0;
      Out_B     <= '0;
      Out_GCD   <= '0;
      Job_count <= '0;
    end else if (CEN) begin
      if (capture) begin
        Out_valid <= 1'b1;
        Out_A     <= cap_a;
        Out_B     <= cap_b;
        Out_GCD   <= cap_gcd;
        Job_count <= Job_count + 8'd1;
      end else if (Out_valid && Out_ready) begin
        Out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ee201_gcd_dispatcher.sv
// tb_ee201_gcd_dispatcher: directed vectors plus multi-cycle corner sequences.
// A small GCD core model answers Start pulses when auto mode is enabled.
module tb_ee201_gcd_dispatcher;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       CEN = 1'b1;
  logic       In_valid = 1'b0;
  logic       Out_ready = 1'b0;
  logic [7:0] In_A = '0;
  logic [7:0] In_B = '0;
  logic       In_ready, Start, Ack, Out_valid, Busy, q_Done;
  logic [7:0] Ain, Bin, AB_GCD, Out_A, Out_B, Out_GCD, Job_count;

  logic       core_auto = 1'b0;
  logic       auto_done = 1'b0;
  logic       man_done = 1'b0;
  logic [7:0] auto_gcd = '0;
  logic [7:0] man_gcd = '0;
  int         cd = 0;

  int n_cmp = 0;
  int n_bad = 0;
  int start_cnt = 0;
  int exp_jobs = 0;
  int rd = 0;
  int s0;
  logic rdy;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] g;
  } res_t;

  res_t got[$];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] g;
  } vec_t;

  vec_t vecs[11];

  assign q_Done = core_auto ? auto_done : man_done;
  assign AB_GCD = core_auto ? auto_gcd : man_gcd;

  ee201_gcd_dispatcher #(.FIFO_DEPTH(4)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .CEN(CEN),
    .In_valid(In_valid), .In_ready(In_ready),
    .In_A(In_A), .In_B(In_B),
    .Ain(Ain), .Bin(Bin), .Start(Start), .Ack(Ack),
    .q_Done(q_Done), .AB_GCD(AB_GCD),
    .Out_valid(Out_valid), .Out_ready(Out_ready),
    .Out_A(Out_A), .Out_B(Out_B), .Out_GCD(Out_GCD),
    .Busy(Busy), .Job_count(Job_count)
  );

  always #5 Clk = ~Clk;

  function automatic logic [7:0] gcd8(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] t;
    x = a;
    y = b;
    while (y != 8'd0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Core model: done three cycles after Start, dropped on Ack.
  always @(negedge Clk) begin
    if (core_auto) begin
      if (Ack) begin
        auto_done = 1'b0;
      end else if (Start) begin
        cd = 3;
        auto_done = 1'b0;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          auto_done = 1'b1;
          auto_gcd = gcd8(Ain, Bin);
        end
      end
    end
  end

  // Record delivered results and enabled Start cycles.
  always @(posedge Clk) begin
    if (Reset_n && CEN && Out_valid && Out_ready)
      got.push_back('{Out_A, Out_B, Out_GCD});
    if (Reset_n && CEN && Start)
      start_cnt++;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push_pair(input logic [7:0] a, input logic [7:0] b,
                           output logic rdy0);
    int k;
    @(negedge Clk);
    In_valid = 1'b1;
    In_A = a;
    In_B = b;
    rdy0 = In_ready;
    k = 0;
    while (!In_ready && k < 300) begin
      @(negedge Clk);
      k++;
    end
    if (!In_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL push_timeout: got %0d expected %0d", In_ready, 1);
    end
  endtask

  task automatic end_push;
    @(negedge Clk);
    In_valid = 1'b0;
  endtask

  task automatic wait_start;
    int k;
    k = 0;
    while (Start !== 1'b1 && k < 50) begin
      @(negedge Clk);
      k++;
    end
    chk("start_seen", Start, 1);
  endtask

  task automatic expect_res(input string nm, input logic [7:0] a,
                            input logic [7:0] b, input logic [7:0] g);
    int k;
    k = 0;
    while (got.size() <= rd && k < 2000) begin
      @(negedge Clk);
      k++;
    end
    if (got.size() <= rd) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got no result expected gcd %0d", nm, g);
    end else begin
      chk({nm, "_a"}, got[rd].a, a);
      chk({nm, "_b"}, got[rd].b, b);
      chk({nm, "_gcd"}, got[rd].g, g);
      rd++;
    end
  endtask

  initial begin
    vecs[0]  = '{8'd24,  8'd36,  8'd12};
    vecs[1]  = '{8'd17,  8'd5,   8'd1};
    vecs[2]  = '{8'd255, 8'd85,  8'd85};
    vecs[3]  = '{8'd100, 8'd75,  8'd25};
    vecs[4]  = '{8'd1,   8'd1,   8'd1};
    vecs[5]  = '{8'd128, 8'd64,  8'd64};
    vecs[6]  = '{8'd48,  8'd180, 8'd12};
    vecs[7]  = '{8'd200, 8'd150, 8'd50};
    vecs[8]  = '{8'd0,   8'd9,   8'd9};
    vecs[9]  = '{8'd7,   8'd0,   8'd7};
    vecs[10] = '{8'd0,   8'd0,   8'd0};

    // Reset state
    Reset_n = 1'b0;
    repeat (2) @(negedge Clk);
    chk("rst_in_ready", In_ready, 1);
    chk("rst_busy", Busy, 0);
    chk("rst_out_valid", Out_valid, 0);
    chk("rst_job", Job_count, 0);
    chk("rst_start", Start, 0);
    chk("rst_ack", Ack, 0);
    chk("rst_ain", Ain, 0);
    chk("rst_out_gcd", Out_GCD, 0);
    @(negedge Clk);
    Reset_n = 1'b1;

    // Single job (24,36) with a hand-driven core
    Out_ready = 1'b1;
    push_pair(8'd24, 8'd36, rdy);
    end_push();
    wait_start();
    chk("j1_ain", Ain, 24);
    chk("j1_bin", Bin, 36);
    @(negedge Clk);
    chk("j1_start_once", Start, 0);
    chk("j1_busy", Busy, 1);
    man_gcd = 8'd12;
    man_done = 1'b1;
    @(negedge Clk);
    man_done = 1'b0;
    exp_jobs = 1;
    chk("j1_valid", Out_valid, 1);
    chk("j1_gcd", Out_GCD, 12);
    chk("j1_ack", Ack, 1);
    chk("j1_job", Job_count, exp_jobs);
    @(negedge Clk);
    chk("j1_ack_once", Ack, 0);
    chk("j1_idle", Busy, 0);
    expect_res("j1", 8'd24, 8'd36, 8'd12);

    // Vector table through the model core; first six push back-to-back
    core_auto = 1'b1;
    for (int i = 0; i < 11; i++) begin
      push_pair(vecs[i].a, vecs[i].b, rdy);
      if (i < 6) chk($sformatf("tab_in_ready%0d", i), rdy, (i < 5) ? 1 : 0);
    end
    end_push();
    for (int i = 0; i < 11; i++) begin
      expect_res($sformatf("tab%0d", i), vecs[i].a, vecs[i].b, vecs[i].g);
    end
    exp_jobs += 11;
    repeat (4) @(negedge Clk);
    chk("tab_job", Job_count, exp_jobs);
    chk("tab_in_ready_end", In_ready, 1);
    core_auto = 1'b0;

    // Result slot blocked: second done must wait for Out_ready
    Out_ready = 1'b0;
    push_pair(8'd12, 8'd18, rdy);
    end_push();
    wait_start();
    @(negedge Clk);
    man_gcd = 8'd6;
    man_done = 1'b1;
    @(negedge Clk);
    chk("blk_ack1", Ack, 1);
    man_done = 1'b0;
    push_pair(8'd20, 8'd30, rdy);
    end_push();
    wait_start();
    @(negedge Clk);
    man_gcd = 8'd10;
    man_done = 1'b1;
    @(negedge Clk);
    chk("blk_busy", Busy, 1);
    chk("blk_ack0", Ack, 0);
    chk("blk_gcd_old", Out_GCD, 6);
    chk("blk_valid", Out_valid, 1);
    @(negedge Clk);
    chk("blk_ack0b", Ack, 0);
    Out_ready = 1'b1;
    @(negedge Clk);
    man_done = 1'b0;
    chk("blk_ack2", Ack, 1);
    chk("blk_gcd_new", Out_GCD, 10);
    chk("blk_a_new", Out_A, 20);
    chk("blk_valid2", Out_valid, 1);
    expect_res("blk1", 8'd12, 8'd18, 8'd6);
    expect_res("blk2", 8'd20, 8'd30, 8'd10);
    exp_jobs += 2;
    chk("blk_job", Job_count, exp_jobs);

    // Clock enable low for five cycles in D_WAIT with done pending
    push_pair(8'd9, 8'd6, rdy);
    end_push();
    wait_start();
    @(negedge Clk);
    man_gcd = 8'd3;
    man_done = 1'b1;
    CEN = 1'b0;
    In_valid = 1'b1;
    In_A = 8'd77;
    In_B = 8'd77;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      chk("cen_busy", Busy, 1);
      chk("cen_valid", Out_valid, 0);
      chk("cen_ack", Ack, 0);
      chk("cen_ain", Ain, 9);
      chk("cen_job", Job_count, exp_jobs);
    end
    CEN = 1'b1;
    In_valid = 1'b0;
    @(negedge Clk);
    man_done = 1'b0;
    exp_jobs++;
    chk("cen_cap_valid", Out_valid, 1);
    chk("cen_cap_gcd", Out_GCD, 3);
    chk("cen_cap_ack", Ack, 1);
    expect_res("cen", 8'd9, 8'd6, 8'd3);
    repeat (2) @(negedge Clk);
    chk("cen_no_push", Busy, 0);

    // Reset in D_WAIT with a result pending and a queued pair
    Out_ready = 1'b0;
    push_pair(8'd50, 8'd20, rdy);
    end_push();
    wait_start();
    @(negedge Clk);
    man_gcd = 8'd10;
    man_done = 1'b1;
    @(negedge Clk);
    man_done = 1'b0;
    push_pair(8'd8, 8'd4, rdy);
    push_pair(8'd3, 8'd3, rdy);
    end_push();
    wait_start();
    @(negedge Clk);
    chk("rw_busy_pre", Busy, 1);
    Reset_n = 1'b0;
    @(negedge Clk);
    exp_jobs = 0;
    chk("rw_busy", Busy, 0);
    chk("rw_valid", Out_valid, 0);
    chk("rw_in_ready", In_ready, 1);
    chk("rw_job", Job_count, exp_jobs);
    chk("rw_start", Start, 0);
    chk("rw_ack", Ack, 0);
    chk("rw_gcd", Out_GCD, 0);
    chk("rw_ain", Ain, 0);
    chk("rw_bin", Bin, 0);
    Reset_n = 1'b1;
    repeat (4) @(negedge Clk);
    chk("rw_fifo_empty", Busy, 0);

    // Zero-operand pair
    Out_ready = 1'b1;
    s0 = start_cnt;
    push_pair(8'd0, 8'd9, rdy);
    end_push();
`ifdef ZERO_BYPASS_EN
    expect_res("zero", 8'd0, 8'd9, 8'd9);
    repeat (2) @(negedge Clk);
    chk("zero_no_start", start_cnt - s0, 0);
    chk("zero_idle", Busy, 0);
    exp_jobs++;
    Out_ready = 1'b0;
    push_pair(8'd0, 8'd5, rdy);
    push_pair(8'd6, 8'd0, rdy);
    end_push();
    repeat (3) @(negedge Clk);
    chk("zhold_gcd", Out_GCD, 5);
    chk("zhold_valid", Out_valid, 1);
    Out_ready = 1'b1;
    expect_res("zhold1", 8'd0, 8'd5, 8'd5);
    expect_res("zhold2", 8'd6, 8'd0, 8'd6);
    exp_jobs += 2;
`else
    wait_start();
    chk("zero_ain", Ain, 0);
    chk("zero_bin", Bin, 9);
    @(negedge Clk);
    man_gcd = 8'd9;
    man_done = 1'b1;
    @(negedge Clk);
    man_done = 1'b0;
    expect_res("zero", 8'd0, 8'd9, 8'd9);
    chk("zero_one_start", start_cnt - s0, 1);
    exp_jobs++;
`endif
    repeat (2) @(negedge Clk);
    chk("zero_job", Job_count, exp_jobs);

    // Job counter wrap 255 -> 0
    core_auto = 1'b1;
    s0 = 255 - exp_jobs;
    for (int i = 0; i < s0; i++) begin
      push_pair(8'((i % 250) + 1), 8'((i % 250) + 1), rdy);
    end
    end_push();
    for (int i = 0; i < s0; i++) begin
      expect_res("wrap_run", 8'((i % 250) + 1), 8'((i % 250) + 1),
                 8'((i % 250) + 1));
    end
    repeat (3) @(negedge Clk);
    chk("wrap_255", Job_count, 255);
    push_pair(8'd21, 8'd14, rdy);
    end_push();
    expect_res("wrap_last", 8'd21, 8'd14, 8'd7);
    repeat (3) @(negedge Clk);
    chk("wrap_0", Job_count, 0);
    core_auto = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
